// File: rtl/tone_gen.sv
// Square-wave note generator: synchronizes and debounces 12 note keys, picks the
// lowest pressed key and plays its tone, shifted by octave, on data_out.
module tone_gen #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] keys,
  input  logic [1:0]  octave,
  output logic        data_out,
  output logic        note_active,
  output logic [3:0]  note_idx
);

  localparam logic [19:0] DEB_MAX = 20'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01
  } state_e;

  logic [11:0] sync1_q, sync2_q, kstab_q;
  logic [19:0] deb_q;
  state_e      state_q;
  logic [16:0] hcnt_q;
  logic        data_q, active_q;
  logic [3:0]  idx_q;

  logic [3:0]  sel, reload_idx;
  logic        gate;
  logic [16:0] reload_cnt;

  // Debounce counter clears on the edge where the synchronized vector changes
  // (sync1 holds the value sync2 is about to take).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      kstab_q <= '0;
      deb_q   <= '0;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
      if (sync1_q != sync2_q)  deb_q <= '0;
      else if (deb_q != DEB_MAX) deb_q <= deb_q + 20'd1;
      if (deb_q == DEB_MAX) kstab_q <= sync2_q;
    end
  end

  function automatic logic [16:0] half_period(input logic [3:0] idx);
    case (idx)
      4'd0:    half_period = 17'd95556;
      4'd1:    half_period = 17'd90193;
      4'd2:    half_period = 17'd85131;
      4'd3:    half_period = 17'd80353;
      4'd4:    half_period = 17'd75843;
      4'd5:    half_period = 17'd71586;
      4'd6:    half_period = 17'd67568;
      4'd7:    half_period = 17'd63776;
      4'd8:    half_period = 17'd60197;
      4'd9:    half_period = 17'd56818;
      4'd10:   half_period = 17'd53629;
      default: half_period = 17'd50619;
    endcase
  endfunction

  always_comb begin
    sel = 4'd0;
    for (int i = 11; i >= 0; i--)
      if (kstab_q[i]) sel = 4'(i);
    gate = |kstab_q;
    // After release, the trailing high half replays the last note played.
    reload_idx = gate ? sel : idx_q;
    reload_cnt = (half_period(reload_idx) >> octave) - 17'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      data_q   <= 1'b0;
      active_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          hcnt_q   <= '0;
          data_q   <= 1'b0;
          active_q <= 1'b0;
          idx_q    <= '0;
          if (gate) begin
            state_q  <= RUN;
            hcnt_q   <= reload_cnt;
            data_q   <= 1'b1;
            active_q <= 1'b1;
            idx_q    <= sel;
          end
        end
        RUN: begin
          if (hcnt_q != '0) begin
            hcnt_q <= hcnt_q - 17'd1;
          end else if (gate || !data_q) begin
            data_q <= ~data_q;
            hcnt_q <= reload_cnt;
            idx_q  <= reload_idx;
          end else begin
            state_q  <= IDLE;
            data_q   <= 1'b0;
            active_q <= 1'b0;
            idx_q    <= '0;
            hcnt_q   <= '0;
          end
        end
        default: begin
          state_q  <= IDLE;
          hcnt_q   <= '0;
          data_q   <= 1'b0;
          active_q <= 1'b0;
          idx_q    <= '0;
        end
      endcase
    end
  end

  assign data_out    = data_q;
  assign note_active = active_q;
  assign note_idx    = idx_q;

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen with a short debounce window; half-period lengths come from
// the note table and octave shift computed directly in the bench.
module tb_tone_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] keys;
  logic [1:0]  octave;
  logic        data_out, note_active;
  logic [3:0]  note_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tone_gen #(.DEB_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .keys        (keys),
    .octave      (octave),
    .data_out    (data_out),
    .note_active (note_active),
    .note_idx    (note_idx)
  );

  int half_tbl[12] = '{95556, 90193, 85131, 80353, 75843, 71586,
                       67568, 63776, 60197, 56818, 53629, 50619};

  typedef struct {
    logic [11:0] k;
    logic [1:0]  o;
    int          idx;
    int          half;
  } vec_t;

  vec_t vecs[3];

  function automatic int exp_idx(input logic [11:0] k);
    for (int i = 0; i < 12; i++)
      if (k[i]) return i;
    return 0;
  endfunction

  function automatic int exp_half(input int idx, input int oct);
    return half_tbl[idx] >> oct;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the chosen output equals val or the bound runs out; n = steps taken.
  task automatic wait_sig(input bit use_data, input logic val, input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (((use_data ? data_out : note_active) !== val) && n < bound);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    keys   = '0;
    octave = '0;
    step();
    step();
    reset  = 1'b0;
  endtask

  // Press, check latency/index, release during the first high half and time it.
  task automatic play_release_high(input logic [11:0] k, input logic [1:0] o,
                                   input int eidx, input int ehalf, input string tag);
    int n;
    do_reset();
    keys   = k;
    octave = o;
    wait_sig(1'b0, 1'b1, 50, n);
    chk($sformatf("%s latency", tag), n, 7);
    chk($sformatf("%s note_idx", tag), note_idx, eidx);
    chk($sformatf("%s data_out high", tag), data_out, 1);
    keys = '0;
    wait_sig(1'b1, 1'b0, ehalf + 50, n);
    chk($sformatf("%s high half", tag), n, ehalf);
    chk($sformatf("%s idle active", tag), note_active, 0);
    chk($sformatf("%s idle idx", tag), note_idx, 0);
  endtask

  initial begin
    int n, hi;
    logic [11:0] rk;

    vecs[0] = '{k: 12'h200, o: 2'd3, idx: 9,  half: 7102};
    vecs[1] = '{k: 12'h201, o: 2'd3, idx: 0,  half: 11944};
    vecs[2] = '{k: 12'h800, o: 2'd3, idx: 11, half: 6327};

    do_reset();
    chk("reset data_out", data_out, 0);
    chk("reset note_active", note_active, 0);
    chk("reset note_idx", note_idx, 0);

    foreach (vecs[i])
      play_release_high(vecs[i].k, vecs[i].o, vecs[i].idx, vecs[i].half,
                        $sformatf("vec%0d", i));

    for (int t = 0; t < 2; t++) begin
      rk = 12'($urandom_range(1, 4095));
      play_release_high(rk, 2'd3, exp_idx(rk), exp_half(exp_idx(rk), 3),
                        $sformatf("rand%0d", t));
    end

    // 3-cycle glitch must never reach the oscillator
    do_reset();
    keys = 12'h004;
    step(); step(); step();
    keys = '0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (note_active !== 1'b0) hi++;
    end
    chk("glitch note_active", hi, 0);

    // Note change mid-half, then release during the low half
    do_reset();
    keys   = 12'h800;
    octave = 2'd3;
    wait_sig(1'b0, 1'b1, 50, n);
    chk("chg latency", n, 7);
    for (int i = 0; i < 100; i++) step();
    keys = 12'h400;
    for (int i = 0; i < 20; i++) step();
    chk("chg idx held mid-half", note_idx, 11);
    wait_sig(1'b1, 1'b0, 7000, n);
    chk("chg B high half", n + 120, 6327);
    chk("chg idx at boundary", note_idx, 10);
    for (int i = 0; i < 100; i++) step();
    keys = '0;
    for (int i = 0; i < 20; i++) step();
    chk("rel-low still active", note_active, 1);
    wait_sig(1'b1, 1'b1, 7000, n);
    chk("rel-low low half", n + 120, 6703);
    chk("rel-low trailing idx", note_idx, 10);
    chk("rel-low trailing active", note_active, 1);
    wait_sig(1'b1, 1'b0, 7000, n);
    chk("rel-low trailing high", n, 6703);
    chk("rel-low idle", note_active, 0);

    // Reset pulse in the middle of a tone with the key still held
    do_reset();
    keys   = 12'h800;
    octave = 2'd3;
    wait_sig(1'b0, 1'b1, 50, n);
    for (int i = 0; i < 100; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset data_out", data_out, 0);
    chk("midreset note_active", note_active, 0);
    chk("midreset note_idx", note_idx, 0);
    wait_sig(1'b0, 1'b1, 50, n);
    chk("midreset resume latency", n, 7);
    keys = '0;
    wait_sig(1'b1, 1'b0, 7000, n);
    chk("midreset high half", n, 6327);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
